// File: rtl/regfile_write_arbiter_if.sv
// Writeback request/response bundle for the register-file write arbiter.
// Master drives the two source requests; slave returns ready and the write port.
interface regfile_write_arbiter_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
);
   logic              AluValid;
   logic              AluReady;
   logic [ADDR_W-1:0] AluRW;
   logic [DATA_W-1:0] AluData;
   logic              MemValid;
   logic              MemReady;
   logic [ADDR_W-1:0] MemRW;
   logic [DATA_W-1:0] MemData;
   logic              RegWr;
   logic [ADDR_W-1:0] RW;
   logic [DATA_W-1:0] BusW;

   modport master (
      output AluValid, AluRW, AluData,
      output MemValid, MemRW, MemData,
      input  AluReady, MemReady,
      input  RegWr, RW, BusW
   );

   modport slave (
      input  AluValid, AluRW, AluData,
      input  MemValid, MemRW, MemData,
      output AluReady, MemReady,
      output RegWr, RW, BusW
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writebacks.
// RR_ARB_EN selects round-robin; otherwise Mem-first with an ALU starve guard.
module regfile_write_arbiter #(
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 5,
   parameter int ZERO_REG   = 31,
   parameter int STARVE_MAX = 4
) (
   input logic                    Clk,
   input logic                    Reset_n,
   regfile_write_arbiter_if.slave bus
);
   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

   logic              aluFull;
   logic [ADDR_W-1:0] aluRW;
   logic [DATA_W-1:0] aluData;
   logic              memFull;
   logic [ADDR_W-1:0] memRW;
   logic [DATA_W-1:0] memData;
   logic              memOlder;
   logic              aluIssue;
   logic              memIssue;
   logic              aluAcc;
   logic              memAcc;
   logic              aluFill;
   logic              memFill;
   logic              bothFull;
   logic              sameDst;
   logic              regWr;
   logic [ADDR_W-1:0] rw;
   logic [DATA_W-1:0] busW;

`ifdef RR_ARB_EN
   logic lastAlu;
`else
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   logic [CNT_W-1:0] starve;
`endif

   assign bothFull = aluFull && memFull;
   assign sameDst  = bothFull && (aluRW == memRW);

   // Pick at most one slot to issue; same-destination age order always wins
   always_comb begin
      aluIssue = 1'b0;
      memIssue = 1'b0;
      if (bothFull) begin
         if (sameDst) begin
            memIssue = memOlder;
            aluIssue = !memOlder;
         end
`ifdef RR_ARB_EN
         else if (lastAlu) begin
            memIssue = 1'b1;
         end else begin
            aluIssue = 1'b1;
         end
`else
         else if (starve >= CNT_W'(STARVE_MAX)) begin
            aluIssue = 1'b1;
         end else begin
            memIssue = 1'b1;
         end
`endif
      end else begin
         aluIssue = aluFull;
         memIssue = memFull;
      end
   end

   assign bus.AluReady = !aluFull || aluIssue;
   assign bus.MemReady = !memFull || memIssue;
   assign aluAcc  = bus.AluValid && bus.AluReady;
   assign memAcc  = bus.MemValid && bus.MemReady;
   assign aluFill = aluAcc && (bus.AluRW != ZERO_IDX);
   assign memFill = memAcc && (bus.MemRW != ZERO_IDX);

   // Holding slots: refill on accept, free on issue; zero-reg requests vanish
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         aluFull  <= 1'b0;
         aluRW    <= '0;
         aluData  <= '0;
         memFull  <= 1'b0;
         memRW    <= '0;
         memData  <= '0;
         memOlder <= 1'b1;
      end else begin
         if (aluFill) begin
            aluFull <= 1'b1;
            aluRW   <= bus.AluRW;
            aluData <= bus.AluData;
         end else if (aluIssue) begin
            aluFull <= 1'b0;
         end
         if (memFill) begin
            memFull <= 1'b1;
            memRW   <= bus.MemRW;
            memData <= bus.MemData;
         end else if (memIssue) begin
            memFull <= 1'b0;
         end
         if (aluFill) begin
            memOlder <= 1'b1;
         end else if (memFill) begin
            memOlder <= 1'b0;
         end
      end
   end

   // Registered write pulse; index and data hold when nothing issues
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         regWr <= 1'b0;
         rw    <= '0;
         busW  <= '0;
      end else begin
         regWr <= aluIssue || memIssue;
         if (memIssue) begin
            rw   <= memRW;
            busW <= memData;
         end else if (aluIssue) begin
            rw   <= aluRW;
            busW <= aluData;
         end
      end
   end

`ifdef RR_ARB_EN
   // Remember who won the last contended cycle so the other goes next
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         lastAlu <= 1'b1;
      end else if (bothFull) begin
         lastAlu <= aluIssue;
      end
   end
`else
   // Count cycles a waiting ALU entry loses; saturates at the forced-win point
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         starve <= '0;
      end else if (!aluFull || aluIssue) begin
         starve <= '0;
      end else if (starve < CNT_W'(STARVE_MAX)) begin
         starve <= starve + CNT_W'(1);
      end
   end
`endif

   assign bus.RegWr = regWr;
   assign bus.RW    = rw;
   assign bus.BusW  = busW;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: per-cycle vector table plus reset sequence.
// Expected writes are queued as vectors are driven and checked after each edge.
module tb_regfile_write_arbiter;
   typedef struct {
      logic        av;
      logic [4:0]  arw;
      logic [63:0] ad;
      logic        mv;
      logic [4:0]  mrw;
      logic [63:0] md;
      logic        ardy;
      logic        mrdy;
      logic        wr;
      logic [4:0]  rw;
      logic [63:0] bw;
   } vec_t;

   typedef struct packed {
      logic        wr;
      logic [4:0]  rw;
      logic [63:0] bw;
   } exp_t;

   localparam logic [63:0] DB = 64'h0000_0000_DEAD_BEEF;
   localparam logic [63:0] A2 = 64'h0000_2222_0000_2222;
   localparam logic [63:0] M1 = 64'h1111_0000_1111_0000;
   localparam logic [63:0] A7 = 64'h0000_0000_0000_A7A7;
   localparam logic [63:0] M3 = 64'h0000_0000_0000_3333;
   localparam logic [63:0] B7 = 64'h0000_0000_B7B7_B7B7;
   localparam logic [63:0] ZD = 64'h0000_0000_0000_FFFF;
   localparam int NV = 21;

   logic Clk;
   logic Reset_n;
   int   checks;
   int   errors;
   vec_t tbl[NV];
   exp_t q[$];
   exp_t e;

   regfile_write_arbiter_if #(.DATA_W(64), .ADDR_W(5)) bus ();

   regfile_write_arbiter dut (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .bus    (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic av, input logic [4:0] arw, input logic [63:0] ad,
      input logic mv, input logic [4:0] mrw, input logic [63:0] md,
      input logic ardy, input logic mrdy,
      input logic wr, input logic [4:0] rw, input logic [63:0] bw);
      vec_t v;
      v.av = av; v.arw = arw; v.ad = ad;
      v.mv = mv; v.mrw = mrw; v.md = md;
      v.ardy = ardy; v.mrdy = mrdy;
      v.wr = wr; v.rw = rw; v.bw = bw;
      return v;
   endfunction

   task automatic drive(input logic av, input logic [4:0] arw,
                        input logic [63:0] ad, input logic mv,
                        input logic [4:0] mrw, input logic [63:0] md);
      bus.AluValid = av;
      bus.AluRW    = arw;
      bus.AluData  = ad;
      bus.MemValid = mv;
      bus.MemRW    = mrw;
      bus.MemData  = md;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      Reset_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);

      // single ALU write, then zero-register absorption
      tbl[0]  = mk(1, 5, DB, 0, 0, 0, 1, 1, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 5, DB);
      tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 5, DB);
      tbl[3]  = mk(1, 31, ZD, 0, 0, 0, 1, 1, 0, 5, DB);
      tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 5, DB);
      tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 5, DB);
      // sustained contention, then drain
      tbl[6]  = mk(1, 2, A2, 1, 1, M1, 1, 1, 0, 5, DB);
`ifdef RR_ARB_EN
      tbl[7]  = mk(1, 2, A2, 1, 1, M1, 0, 1, 1, 1, M1);
      tbl[8]  = mk(1, 2, A2, 1, 1, M1, 1, 0, 1, 2, A2);
      tbl[9]  = mk(1, 2, A2, 1, 1, M1, 0, 1, 1, 1, M1);
      tbl[10] = mk(1, 2, A2, 1, 1, M1, 1, 0, 1, 2, A2);
      tbl[11] = mk(1, 2, A2, 1, 1, M1, 0, 1, 1, 1, M1);
      tbl[12] = mk(1, 2, A2, 1, 1, M1, 1, 0, 1, 2, A2);
`else
      tbl[7]  = mk(1, 2, A2, 1, 1, M1, 0, 1, 1, 1, M1);
      tbl[8]  = mk(1, 2, A2, 1, 1, M1, 0, 1, 1, 1, M1);
      tbl[9]  = mk(1, 2, A2, 1, 1, M1, 0, 1, 1, 1, M1);
      tbl[10] = mk(1, 2, A2, 1, 1, M1, 0, 1, 1, 1, M1);
      tbl[11] = mk(1, 2, A2, 1, 1, M1, 1, 0, 1, 2, A2);
      tbl[12] = mk(1, 2, A2, 1, 1, M1, 0, 1, 1, 1, M1);
`endif
      tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, M1);
      tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 2, A2);
      tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2, A2);
      // same destination register: older ALU entry must go first
      tbl[16] = mk(1, 7, A7, 1, 3, M3, 1, 1, 0, 2, A2);
`ifdef RR_ARB_EN
      tbl[17] = mk(0, 0, 0, 1, 7, B7, 1, 0, 1, 7, A7);
      tbl[18] = mk(0, 0, 0, 1, 7, B7, 1, 1, 1, 3, M3);
`else
      tbl[17] = mk(0, 0, 0, 1, 7, B7, 0, 1, 1, 3, M3);
      tbl[18] = mk(0, 0, 0, 1, 7, B7, 1, 0, 1, 7, A7);
`endif
      tbl[19] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 7, B7);
      tbl[20] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 7, B7);

      #1;
      chk("rst_regwr", 64'(bus.RegWr), 64'd0);
      chk("rst_rw", 64'(bus.RW), 64'd0);
      chk("rst_busw", bus.BusW, 64'd0);
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      #1;
      chk("rst_aluready", 64'(bus.AluReady), 64'd1);
      chk("rst_memready", 64'(bus.MemReady), 64'd1);

      for (int i = 0; i < NV; i++) begin
         @(negedge Clk);
         drive(tbl[i].av, tbl[i].arw, tbl[i].ad,
               tbl[i].mv, tbl[i].mrw, tbl[i].md);
         #1;
         chk($sformatf("v%0d_aluready", i), 64'(bus.AluReady),
             64'(tbl[i].ardy));
         chk($sformatf("v%0d_memready", i), 64'(bus.MemReady),
             64'(tbl[i].mrdy));
         q.push_back({tbl[i].wr, tbl[i].rw, tbl[i].bw});
         @(posedge Clk);
         #1;
         e = q.pop_front();
         chk($sformatf("v%0d_regwr", i), 64'(bus.RegWr), 64'(e.wr));
         chk($sformatf("v%0d_rw", i), 64'(bus.RW), 64'(e.rw));
         chk($sformatf("v%0d_busw", i), bus.BusW, e.bw);
      end

      // reset while both slots hold entries and a write is in flight
      @(negedge Clk);
      drive(1, 9, 64'h99, 1, 10, 64'h1010);
      @(negedge Clk);
      drive(0, 0, 0, 0, 0, 0);
      @(posedge Clk);
      #1;
      chk("mid_regwr", 64'(bus.RegWr), 64'd1);
      chk("mid_rw", 64'(bus.RW), 64'd10);
      #1;
      Reset_n = 1'b0;
      #1;
      chk("async_regwr", 64'(bus.RegWr), 64'd0);
      chk("async_rw", 64'(bus.RW), 64'd0);
      chk("async_busw", bus.BusW, 64'd0);
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk);
         #1;
         chk($sformatf("post_rst_regwr%0d", i), 64'(bus.RegWr), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
